pipelined_adder: RTL and testbench

- Parametrised successor to the single-bit full adder: a WIDTH-bit adder with carry-in, split into STAGES register-separated ripple slices.
- Sustains one addition per clock with a valid/ready handshake on both sides.
- Outputs sum, carry-out and signed overflow.
- Serves as the arithmetic building block for the team's datapath projects (accumulators, ALU).

---
 rtl/adder_pkg.sv | 19 +
 rtl/add_slice.sv | 32 +++
 rtl/pipelined_adder.sv | 118 +++++++++++
 tb/tb_pipelined_adder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
package adder_pkg;

   // Per-stage control record; operand and sum slices are kept in arrays sized by the top.
   typedef struct packed {
      logic valid;
      logic carry;
      logic ovf;
   } stage_ctl_t;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple adder; each cell is a full adder built from two half adders.
module add_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   logic [W:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < W; gi++) begin : g_cell
      logic h1_sum;
      logic h1_carry;
      logic h2_carry;

      assign h1_sum       = a[gi] ^ b[gi];
      assign h1_carry     = a[gi] & b[gi];
      assign sum[gi]      = h1_sum ^ carry[gi];
      assign h2_carry     = h1_sum & carry[gi];
      assign carry[gi+1]  = h1_carry | h2_carry;
   end

   assign cout  = carry[W];
   assign c_msb = carry[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES registered ripple slices with valid/ready on both sides.
// Optional macro PIPELINED_ADDER_SUB_EN adds in_sub, turning the block into A - B when set.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SLICE_W = slice_width(WIDTH, STAGES);

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
   assign b_eff   = in_sub ? ~in_b : in_b;
   assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
   assign b_eff   = in_b;
   assign cin_eff = in_cin;
`endif

   // Single stall signal: the whole pipe, bubbles included, moves or holds together.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic [WIDTH-1:0]   a_src     [STAGES];
   logic [WIDTH-1:0]   b_src     [STAGES];
   logic [WIDTH-1:0]   sum_src   [STAGES];
   logic               cin_src   [STAGES];
   logic               valid_src [STAGES];
   logic [SLICE_W-1:0] slice_sum [STAGES];
   logic               slice_cout[STAGES];
   logic               slice_cmsb[STAGES];
   logic [WIDTH-1:0]   sum_next  [STAGES];
   stage_ctl_t         ctl_next  [STAGES];

   logic [WIDTH-1:0]   a_reg     [STAGES];
   logic [WIDTH-1:0]   b_reg     [STAGES];
   logic [WIDTH-1:0]   sum_reg   [STAGES];
   stage_ctl_t         ctl_reg   [STAGES];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign a_src[gi]     = in_a;
         assign b_src[gi]     = b_eff;
         assign sum_src[gi]   = '0;
         assign cin_src[gi]   = cin_eff;
         assign valid_src[gi] = in_valid;
      end else begin : g_body
         assign a_src[gi]     = a_reg[gi-1];
         assign b_src[gi]     = b_reg[gi-1];
         assign sum_src[gi]   = sum_reg[gi-1];
         assign cin_src[gi]   = ctl_reg[gi-1].carry;
         assign valid_src[gi] = ctl_reg[gi-1].valid;
      end

      add_slice #(.W(SLICE_W)) u_slice (
         .a     (a_src[gi][gi*SLICE_W +: SLICE_W]),
         .b     (b_src[gi][gi*SLICE_W +: SLICE_W]),
         .cin   (cin_src[gi]),
         .sum   (slice_sum[gi]),
         .cout  (slice_cout[gi]),
         .c_msb (slice_cmsb[gi])
      );

      // Slices above this one are still zero, so the new slice can simply be OR-ed in.
      assign sum_next[gi] = sum_src[gi] | (WIDTH'(slice_sum[gi]) << (gi*SLICE_W));
      assign ctl_next[gi] = '{valid: valid_src[gi],
                              carry: slice_cout[gi],
                              ovf:   slice_cout[gi] ^ slice_cmsb[gi]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_reg[k] <= '0;
            sum_reg[k] <= '0;
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_reg[k] <= ctl_next[k];
            sum_reg[k] <= sum_next[k];
            a_reg[k]   <= a_src[k];
            b_reg[k]   <= b_src[k];
         end
      end
   end

   assign out_valid = ctl_reg[STAGES-1].valid;
   assign out_sum   = sum_reg[STAGES-1];
   assign out_cout  = ctl_reg[STAGES-1].carry;
   assign out_ovf   = ctl_reg[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: vector table, scoreboard queue and corner-case sequences.
// Build with PIPELINED_ADDER_SUB_EN to exercise the subtract port (STAGES becomes 4).
module tb_pipelined_adder;

   localparam int W = 8;
`ifdef PIPELINED_ADDER_SUB_EN
   localparam int S = 4;
`else
   localparam int S = 2;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
`ifdef PIPELINED_ADDER_SUB_EN
   logic         in_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   int   checks = 0;
   int   errors = 0;
   int   run_len = 0;
   int   max_run = 0;
   res_t exp_q[$];
   res_t mon_e;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef PIPELINED_ADDER_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic sub, input logic [W-1:0] sum, input logic cout,
                               input logic ovf);
      res_t r;
      r.a = a; r.b = b; r.cin = cin; r.sub = sub;
      r.sum = sum; r.cout = cout; r.ovf = ovf;
      return r;
   endfunction

   // Reference straight from the arithmetic definition of sum, carry and signed overflow.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic         c;
      logic [W:0]   full;
      bb   = sub ? ~b : b;
      c    = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
      return mk(a, b, cin, sub, full[W-1:0], full[W],
                (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]));
   endfunction

   // Scoreboard: every output transfer pops one expected result in order.
   always @(negedge clk) begin
      if (rst) begin
         run_len = 0;
      end else if (out_valid && out_ready) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got sum=%h cout=%0d ovf=%0d, required no output",
                     out_sum, out_cout, out_ovf);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_sum !== mon_e.sum || out_cout !== mon_e.cout || out_ovf !== mon_e.ovf) begin
               errors++;
               $display("FAIL result a=%h b=%h cin=%0d sub=%0d: got sum=%h cout=%0d ovf=%0d, required sum=%h cout=%0d ovf=%0d",
                        mon_e.a, mon_e.b, mon_e.cin, mon_e.sub, out_sum, out_cout, out_ovf,
                        mon_e.sum, mon_e.cout, mon_e.ovf);
            end else begin
               $display("ok a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                        mon_e.a, mon_e.b, mon_e.cin, mon_e.sub, out_sum, out_cout, out_ovf);
            end
         end
      end else begin
         run_len = 0;
      end
   end

   // Called at posedge+1; leaves in_valid high so consecutive calls are back-to-back.
   task automatic send(input res_t e);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_a     = e.a;
      in_b     = e.b;
      in_cin   = e.cin;
`ifdef PIPELINED_ADDER_SUB_EN
      in_sub   = e.sub;
`endif
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   res_t vecs[8];

   initial begin
      int lat;
      int w;

      vecs[0] = mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      vecs[1] = mk(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      vecs[2] = mk(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      vecs[3] = mk(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      vecs[4] = mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      vecs[5] = mk(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      vecs[6] = mk(8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      vecs[7] = mk(8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
      in_sub    = 1'b0;
`endif
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0d sum=%h cout=%0d ovf=%0d, required all 0",
                  out_valid, out_sum, out_cout, out_ovf);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %0d, required 1", in_ready);
      end

      // Vector table, back-to-back
      for (int i = 0; i < 8; i++) send(vecs[i]);
      idle();
      drain();

      // Latency of a lone wrap transaction
      send(vecs[0]);
      idle();
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != S) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required %0d", lat, S);
      end
      drain();

      // Backpressure: hold the output for 4 cycles while three inputs queue up
      out_ready = 1'b0;
      fork
         begin
            send(mk(8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0));
            send(mk(8'h20, 8'h02, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0));
            send(mk(8'h30, 8'h03, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0));
            idle();
         end
         begin
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 50) begin
               @(negedge clk);
               w++;
            end
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_sum === 8'h11 &&
                     out_cout === 1'b0 && out_ovf === 1'b0)) begin
                  errors++;
                  $display("FAIL stall_hold cycle %0d: got valid=%0d in_ready=%0d sum=%h, required valid=1 in_ready=0 sum=11",
                           i, out_valid, in_ready, out_sum);
               end
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

`ifdef PIPELINED_ADDER_SUB_EN
      // Subtraction: 5 - 7
      send(mk(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0));
      send(mk(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0));
      send(mk(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1));
      idle();
      drain();
`endif

      // Throughput: 16 random transactions with no stalls
      max_run = 0;
      for (int i = 0; i < 16; i++) begin
`ifdef PIPELINED_ADDER_SUB_EN
         send(model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
`else
         send(model(W'($urandom), W'($urandom), 1'($urandom), 1'b0));
`endif
      end
      idle();
      drain();
      checks++;
      if (max_run != 16) begin
         errors++;
         $display("FAIL throughput_run: got %0d consecutive results, required 16", max_run);
      end

      // Reset with two transactions in flight
      send(mk(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0));
      send(mk(8'h04, 8'h05, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0));
      idle();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_cout !== 1'b0 || out_ovf !== 1'b0 ||
          in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midflight_reset: got valid=%0d sum=%h cout=%0d ovf=%0d in_ready=%0d, required 0 00 0 0 1",
                  out_valid, out_sum, out_cout, out_ovf, in_ready);
      end
      for (int i = 0; i < S + 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_output cycle %0d: got out_valid=%0d sum=%h, required out_valid=0",
                     i, out_valid, out_sum);
         end
      end

      // Pipe still works after the reset
      @(posedge clk);
      #1;
      send(vecs[1]);
      idle();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
